pulse_width_decoder: RTL and testbench
======================================

Name: pulse_width_decoder

Overview:
Receive-side counterpart of the team's fixed-width pulse generators. It measures the high time of an asynchronous incoming pulse in `clk` cycles, then reports the width with a one-cycle `valid` strobe. Each result is classified as short or long against configured limits. It sits on the receive side of pulse-coded control links, for example to decode delayed or one-shot pulses arriving from another clock domain or board.

Parameters:
COUNT_WIDTH, 5, bit width of the width counter and of `width`; saturation value is 2^COUNT_WIDTH-1.
MIN_WIDTH, 2, measured widths below this set `too_short`.
MAX_WIDTH, 20, measured widths above this set `too_long`.
Legal range: 1 <= MIN_WIDTH <= MAX_WIDTH < 2^COUNT_WIDTH-1.

Ports:
clk  input  1  system clock, all state on its rising edge
reset  input  1  asynchronous, active-high reset
pulse_in  input  1  asynchronous pulse to measure
width  output  COUNT_WIDTH  last measured high time in clk cycles
valid  output  1  one-cycle strobe: new result on width and flags
too_short  output  1  last result < MIN_WIDTH
too_long  output  1  last result > MAX_WIDTH, or saturated
overflow  output  1  last result saturated (pulse exceeded counter range)
busy  output  1  high while a pulse is being measured (MEASURE or OVERFLOW)

Behaviour:
- Synchronizer and edge detect
  - Two-flop synchronizer on pulse_in gives s. A third flop holds p, the previous s.
  - rise = s & ~p; fall = ~s & p.
  - Reset forces both synchronizer flops and p to 1, so a pulse already high at reset release is never measured as a partial pulse.
- Reset values: width=0, valid=0, too_short=0, too_long=0, overflow=0, busy=0, count=0, state=WAIT_LOW.
- Reset is asynchronous and may arrive mid-operation. It aborts any measurement with no valid emitted.
- States:
  - WAIT_LOW: ignore input. Go to IDLE on the first cycle with s==0.
  - IDLE: on rise, count<=1 and go to MEASURE.
  - MEASURE, on fall:
    - width<=count, valid<=1, overflow<=0;
    - too_short<=(count<MIN_WIDTH); too_long<=(count>MAX_WIDTH);
    - go to IDLE.
  - MEASURE, s==1 and count==2^COUNT_WIDTH-1:
    - width<=all ones, valid<=1, overflow<=1, too_long<=1, too_short<=0;
    - go to OVERFLOW.
  - MEASURE, otherwise (s==1): count<=count+1.
  - OVERFLOW: no counting, no further valid. Go to IDLE on fall.
- Width definition: count equals the number of cycles s was high, so a pulse_in high for N sampled edges reports width=N.
- Latency: valid is high after the 3rd rising clk edge counted from the first edge that samples pulse_in low (2 synchronizer stages + 1 registered output).
- valid is exactly one cycle wide. width and the flags hold their values until the next valid or reset.
- Simultaneous events:
  - fall in the same cycle as count==max is a normal report: width=max, overflow=0, too_long per compare.
- Back-to-back pulses:
  - A rise in the cycle immediately after a fall (IDLE) starts a new measurement. A one-cycle low gap is legal.
  - Pulses narrower than one clk may be missed; this is not flagged.
- busy = state is MEASURE or OVERFLOW (registered from state).

Test Plan:
- Defaults; pulse_in high for 7 clk, then low -> single valid, width=7, too_short=0, too_long=0, overflow=0, valid 3 edges after the fall.
- pulse_in high 1 clk -> width=1, too_short=1. Then high 25 clk -> width=25, too_long=1, too_short=0.
- pulse_in high 40 clk -> valid once when count hits 31: width=31, overflow=1, too_long=1. No second valid on the fall. busy stays high until the fall is detected.
- Reset released while pulse_in high for 10 more clk -> no valid. Next 5-clk pulse -> width=5.
- Reset asserted 4 clk into an 8-clk pulse -> all outputs 0 immediately, no valid for that pulse. Next 6-clk pulse -> width=6.
- Back-to-back: high 3, low 1, high 4, low -> two valids, width=3 (too_short=0) then width=4, with no lost or merged pulses.

Source files
------------

// File: rtl/pulse_width_decoder.sv
// Measures the high time of an asynchronous pulse in clk cycles and reports it
// with a one-cycle valid strobe plus short/long/overflow classification.
module pulse_width_decoder #(
  parameter int COUNT_WIDTH = 5,
  parameter int MIN_WIDTH   = 2,
  parameter int MAX_WIDTH   = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pulse_in,
  output logic [COUNT_WIDTH-1:0] width,
  output logic                   valid,
  output logic                   too_short,
  output logic                   too_long,
  output logic                   overflow,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_WAIT_LOW = 2'd0,
    ST_IDLE     = 2'd1,
    ST_MEASURE  = 2'd2,
    ST_OVERFLOW = 2'd3
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};
  localparam logic [COUNT_WIDTH-1:0] MIN_W   = COUNT_WIDTH'(MIN_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] MAX_W   = COUNT_WIDTH'(MAX_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic                   sync1_q, sync1_d;
  logic                   sync2_q, sync2_d;
  logic                   prev_q, prev_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] width_q, width_d;
  logic                   valid_q, valid_d;
  logic                   too_short_q, too_short_d;
  logic                   too_long_q, too_long_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;
  logic                   rise_s, fall_s;

  assign rise_s = sync2_q & ~prev_q;
  assign fall_s = ~sync2_q & prev_q;

  // Next-state and result computation
  always_comb begin
    sync1_d     = pulse_in;
    sync2_d     = sync1_q;
    prev_d      = sync2_q;
    state_d     = state_q;
    count_d     = count_q;
    width_d     = width_q;
    valid_d     = 1'b0;
    too_short_d = too_short_q;
    too_long_d  = too_long_q;
    overflow_d  = overflow_q;
    case (state_q)
      ST_WAIT_LOW: begin
        if (!sync2_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_LOW;
        end
      end
      ST_IDLE: begin
        if (rise_s) begin
          count_d = CNT_ONE;
          state_d = ST_MEASURE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        // A fall wins over saturation, so width=max with a fall is a normal report
        if (fall_s) begin
          width_d     = count_q;
          valid_d     = 1'b1;
          overflow_d  = 1'b0;
          too_short_d = (count_q < MIN_W);
          too_long_d  = (count_q > MAX_W);
          state_d     = ST_IDLE;
        end else if (sync2_q && (count_q == CNT_MAX)) begin
          width_d     = CNT_MAX;
          valid_d     = 1'b1;
          overflow_d  = 1'b1;
          too_long_d  = 1'b1;
          too_short_d = 1'b0;
          state_d     = ST_OVERFLOW;
        end else if (sync2_q) begin
          count_d = count_q + CNT_ONE;
        end else begin
          state_d = ST_MEASURE;
        end
      end
      ST_OVERFLOW: begin
        if (fall_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OVERFLOW;
        end
      end
      default: begin
        state_d = ST_WAIT_LOW;
      end
    endcase
    busy_d = (state_d == ST_MEASURE) || (state_d == ST_OVERFLOW);
  end

  // State and output registers; synchronizer resets high to skip partial pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      prev_q      <= 1'b1;
      state_q     <= ST_WAIT_LOW;
      count_q     <= '0;
      width_q     <= '0;
      valid_q     <= 1'b0;
      too_short_q <= 1'b0;
      too_long_q  <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      prev_q      <= prev_d;
      state_q     <= state_d;
      count_q     <= count_d;
      width_q     <= width_d;
      valid_q     <= valid_d;
      too_short_q <= too_short_d;
      too_long_q  <= too_long_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
    end
  end

  assign width     = width_q;
  assign valid     = valid_q;
  assign too_short = too_short_q;
  assign too_long  = too_long_q;
  assign overflow  = overflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// Directed bench for pulse_width_decoder: vector table of pulse lengths plus
// hand-written overflow, reset and back-to-back sequences.
module tb_pulse_width_decoder;

  logic       clk;
  logic       reset;
  logic       pulse_in;
  logic [4:0] width;
  logic       valid;
  logic       too_short;
  logic       too_long;
  logic       overflow;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int nvalid = 0;
  int last_valid_cyc = 0;
  int hist_w [0:63];
  int hist_s [0:63];
  int hist_l [0:63];
  int hist_o [0:63];
  int fall_cyc = 0;
  int start_cyc = 0;
  int nv0 = 0;

  typedef struct {
    int hi_len;
    int exp_w;
    int exp_s;
    int exp_l;
  } vec_t;

  vec_t vecs [0:3];

  pulse_width_decoder dut (
    .clk      (clk),
    .reset    (reset),
    .pulse_in (pulse_in),
    .width    (width),
    .valid    (valid),
    .too_short(too_short),
    .too_long (too_long),
    .overflow (overflow),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (valid === 1'b1) begin
        if (nvalid < 64) begin
          hist_w[nvalid] = int'(width);
          hist_s[nvalid] = int'(too_short);
          hist_l[nvalid] = int'(too_long);
          hist_o[nvalid] = int'(overflow);
        end
        last_valid_cyc = cyc;
        nvalid = nvalid + 1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive pulse_in high for n rising edges, then low; note the first low-sampling edge
  task automatic run_pulse(input int n);
    @(negedge clk);
    pulse_in = 1'b1;
    start_cyc = cyc;
    repeat (n) @(negedge clk);
    pulse_in = 1'b0;
    fall_cyc = cyc + 1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_width"}, int'(width), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_short"}, int'(too_short), 0);
    check({tag, "_long"}, int'(too_long), 0);
    check({tag, "_ovf"}, int'(overflow), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{hi_len: 7,  exp_w: 7,  exp_s: 0, exp_l: 0};
    vecs[1] = '{hi_len: 1,  exp_w: 1,  exp_s: 1, exp_l: 0};
    vecs[2] = '{hi_len: 25, exp_w: 25, exp_s: 0, exp_l: 1};
    vecs[3] = '{hi_len: 2,  exp_w: 2,  exp_s: 0, exp_l: 0};

    reset = 1'b1;
    pulse_in = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      nv0 = nvalid;
      run_pulse(vecs[i].hi_len);
      repeat (8) @(negedge clk);
      check($sformatf("v%0d_count", i), nvalid - nv0, 1);
      if (nvalid == nv0 + 1) begin
        check($sformatf("v%0d_width", i), hist_w[nv0], vecs[i].exp_w);
        check($sformatf("v%0d_short", i), hist_s[nv0], vecs[i].exp_s);
        check($sformatf("v%0d_long", i), hist_l[nv0], vecs[i].exp_l);
        check($sformatf("v%0d_ovf", i), hist_o[nv0], 0);
        check($sformatf("v%0d_latency", i), last_valid_cyc - fall_cyc, 2);
      end
      check($sformatf("v%0d_hold_width", i), int'(width), vecs[i].exp_w);
      check($sformatf("v%0d_busy_idle", i), int'(busy), 0);
    end

    // Saturating pulse: one report at count=31, nothing on the eventual fall
    nv0 = nvalid;
    run_pulse(40);
    check("ovf_busy_before_fall", int'(busy), 1);
    check("ovf_count_before_fall", nvalid - nv0, 1);
    if (nvalid == nv0 + 1) begin
      check("ovf_width", hist_w[nv0], 31);
      check("ovf_flag", hist_o[nv0], 1);
      check("ovf_long", hist_l[nv0], 1);
      check("ovf_short", hist_s[nv0], 0);
      check("ovf_latency", last_valid_cyc - start_cyc, 34);
    end
    @(negedge clk);
    check("ovf_busy_at_fall_edge", int'(busy), 1);
    repeat (8) @(negedge clk);
    check("ovf_no_second_valid", nvalid - nv0, 1);
    check("ovf_busy_after", int'(busy), 0);
    check("ovf_hold_flag", int'(overflow), 1);

    // Reset released while pulse_in already high
    @(negedge clk);
    reset = 1'b1;
    pulse_in = 1'b1;
    #1;
    check_zero_outputs("rst_hi");
    @(negedge clk);
    reset = 1'b0;
    nv0 = nvalid;
    repeat (10) @(negedge clk);
    pulse_in = 1'b0;
    repeat (8) @(negedge clk);
    check("rst_hi_no_valid", nvalid - nv0, 0);
    check("rst_hi_width", int'(width), 0);
    run_pulse(5);
    repeat (8) @(negedge clk);
    check("rst_hi_next_count", nvalid - nv0, 1);
    check("rst_hi_next_width", int'(width), 5);

    // Reset asserted 4 cycles into an 8-cycle pulse
    nv0 = nvalid;
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_busy_before", int'(busy), 1);
    reset = 1'b1;
    #1;
    check_zero_outputs("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    pulse_in = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_no_valid", nvalid - nv0, 0);
    run_pulse(6);
    repeat (8) @(negedge clk);
    check("mid_next_count", nvalid - nv0, 1);
    check("mid_next_width", int'(width), 6);

    // Back-to-back: high 3, low 1, high 4
    nv0 = nvalid;
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (3) @(negedge clk);
    pulse_in = 1'b0;
    @(negedge clk);
    pulse_in = 1'b1;
    repeat (4) @(negedge clk);
    pulse_in = 1'b0;
    repeat (8) @(negedge clk);
    check("b2b_count", nvalid - nv0, 2);
    if (nvalid == nv0 + 2) begin
      check("b2b_w0", hist_w[nv0], 3);
      check("b2b_s0", hist_s[nv0], 0);
      check("b2b_w1", hist_w[nv0 + 1], 4);
      check("b2b_l1", hist_l[nv0 + 1], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
